// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing REG_NUM 32-bit read/write registers.
// Write address and write data are latched independently and commit together.
// Reads run concurrently with writes.
// Optional feature: define AXI_LITE_REG_SLAVE_STRB_EN to honour WSTRB byte lanes.
// Without it, every committed write replaces the whole word.
module axi_lite_reg_slave #(
   parameter int S_AXI_DATA_WIDTH = 32,
   parameter int S_AXI_ADDR_WIDTH = 32,
   parameter int REG_NUM          = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic [S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   output logic [S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [REG_NUM*S_AXI_DATA_WIDTH-1:0] reg_bus,
   output logic [REG_NUM-1:0]              wr_pulse
);

   localparam int DW     = S_AXI_DATA_WIDTH;
   localparam int AW     = S_AXI_ADDR_WIDTH;
   localparam int IDX_W  = $clog2(REG_NUM);
   localparam int STRB_W = DW / 8;

   // Registered state
   logic              awready_q, awready_d;
   logic              wready_q,  wready_d;
   logic              arready_q, arready_d;
   logic              aw_held_q, aw_held_d;
   logic [AW-1:0]     aw_addr_q, aw_addr_d;
   logic              w_held_q,  w_held_d;
   logic [DW-1:0]     w_data_q,  w_data_d;
   logic [STRB_W-1:0] w_strb_q,  w_strb_d;
   logic              bvalid_q,  bvalid_d;
   logic [1:0]        bresp_q,   bresp_d;
   logic              rvalid_q,  rvalid_d;
   logic [1:0]        rresp_q,   rresp_d;
   logic [DW-1:0]     rdata_q,   rdata_d;
   logic [REG_NUM*DW-1:0] regs_q, regs_d;
   logic [REG_NUM-1:0]    wr_pulse_q, wr_pulse_d;

   // Combinational helpers
   logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic [AW-1:0]     aw_addr_eff_s;
   logic [DW-1:0]     w_data_eff_s;
   logic [STRB_W-1:0] w_strb_eff_s;
   logic              aw_oor_s, ar_oor_s;
   logic [IDX_W-1:0]  aw_idx_s, ar_idx_s;
   logic [DW-1:0]     merged_s;
   logic              unused_s;

   // A channel beat is taken only when its ready is high; ready is low while a response is pending.
   assign aw_hs_s = S_AXI_AWVALID & awready_q;
   assign w_hs_s  = S_AXI_WVALID  & wready_q;
   assign ar_hs_s = S_AXI_ARVALID & arready_q;

   // A beat presented in the same cycle it is accepted counts as held.
   assign aw_addr_eff_s = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
   assign w_data_eff_s  = w_held_q  ? w_data_q  : S_AXI_WDATA;
   assign w_strb_eff_s  = w_held_q  ? w_strb_q  : S_AXI_WSTRB;
   assign commit_s      = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s) & ~bvalid_q;

   // Any address bit above the word-index field selects a nonexistent register.
   assign aw_oor_s = |(aw_addr_eff_s >> (IDX_W + 2));
   assign ar_oor_s = |(S_AXI_ARADDR  >> (IDX_W + 2));
   assign aw_idx_s = aw_addr_eff_s[IDX_W+1:2];
   assign ar_idx_s = S_AXI_ARADDR[IDX_W+1:2];

`ifdef AXI_LITE_REG_SLAVE_STRB_EN
   // Byte-lane merge of write data into the current register value.
   always_comb begin
      merged_s = regs_q[aw_idx_s*DW +: DW];
      for (int b = 0; b < STRB_W; b++) begin
         if (w_strb_eff_s[b]) begin
            merged_s[8*b +: 8] = w_data_eff_s[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = regs_q[aw_idx_s*DW + 8*b +: 8];
         end
      end
   end
   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_eff_s[1:0], S_AXI_ARADDR[1:0]};
`else
   assign merged_s = w_data_eff_s;
   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_eff_s[1:0], S_AXI_ARADDR[1:0], w_strb_eff_s};
`endif

   // Write path: latch AW/W independently, commit when both are present, hold B until accepted.
   always_comb begin
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      regs_d     = regs_q;
      wr_pulse_d = {REG_NUM{1'b0}};
      if (commit_s) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (aw_oor_s) begin
            bresp_d = 2'b10;
         end else begin
            bresp_d                      = 2'b00;
            regs_d[aw_idx_s*DW +: DW]    = merged_s;
            wr_pulse_d[aw_idx_s]         = 1'b1;
         end
      end else begin
         if (aw_hs_s) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
         end else begin
            aw_held_d = aw_held_q;
         end
         if (w_hs_s) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
         end else begin
            w_held_d = w_held_q;
         end
         if (bvalid_q & S_AXI_BREADY) begin
            bvalid_d = 1'b0;
            bresp_d  = 2'b00;
         end else begin
            bvalid_d = bvalid_q;
         end
      end
      awready_d = ~aw_held_d & ~bvalid_d;
      wready_d  = ~w_held_d  & ~bvalid_d;
   end

   // Read path: capture data on AR handshake from the pre-write register image, hold until accepted.
   always_comb begin
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (ar_hs_s) begin
         rvalid_d = 1'b1;
         if (ar_oor_s) begin
            rresp_d = 2'b10;
            rdata_d = {DW{1'b0}};
         end else begin
            rresp_d = 2'b00;
            rdata_d = regs_q[ar_idx_s*DW +: DW];
         end
      end else if (rvalid_q & S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
      arready_d = ~rvalid_d;
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         arready_q  <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_addr_q  <= {AW{1'b0}};
         w_held_q   <= 1'b0;
         w_data_q   <= {DW{1'b0}};
         w_strb_q   <= {STRB_W{1'b0}};
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         rvalid_q   <= 1'b0;
         rresp_q    <= 2'b00;
         rdata_q    <= {DW{1'b0}};
         regs_q     <= {(REG_NUM*DW){1'b0}};
         wr_pulse_q <= {REG_NUM{1'b0}};
      end else begin
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         arready_q  <= arready_d;
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign reg_bus       = regs_q;
   assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a response scoreboard and register model.
module tb_axi_lite_reg_slave;

   logic         clk = 1'b0;
   logic         areset;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, araddr, wdata, rdata;
   logic [3:0]   wstrb;
   logic [2:0]   awprot, arprot;
   logic [1:0]   bresp, rresp;
   logic [511:0] reg_bus;
   logic [15:0]  wr_pulse;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [31:0] model_q [16];
   logic [1:0]  exp_bresp [$];
   logic [1:0]  exp_rresp [$];
   logic [31:0] exp_rdata [$];
   logic [15:0] exp_pulse;

   axi_lite_reg_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_bus(reg_bus), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
      logic [31:0] res;
`ifdef AXI_LITE_REG_SLAVE_STRB_EN
      res = old;
      for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
`else
      res = data;
      if (strb == 4'hF && old == 32'h0) res = data;
`endif
      return res;
   endfunction

   function automatic logic [511:0] model_bus();
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[32*k +: 32] = model_q[k];
      return v;
   endfunction

   // Record the expected outcome of a write and update the model.
   task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      if ((addr >> 6) == 32'd0) begin
         idx = int'(addr[5:2]);
         model_q[idx] = apply_write(model_q[idx], data, strb);
         exp_bresp.push_back(2'b00);
         exp_pulse = 16'd1 << idx;
      end else begin
         exp_bresp.push_back(2'b10);
         exp_pulse = 16'd0;
      end
   endtask

   task automatic exp_read(input logic [31:0] addr);
      if ((addr >> 6) == 32'd0) begin
         exp_rresp.push_back(2'b00);
         exp_rdata.push_back(model_q[int'(addr[5:2])]);
      end else begin
         exp_rresp.push_back(2'b10);
         exp_rdata.push_back(32'd0);
      end
   endtask

   task automatic drive_aw(input logic [31:0] addr);
      awvalid = 1'b1; awaddr = addr;
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
      wvalid = 1'b1; wdata = data; wstrb = strb;
   endtask

   task automatic pop_b(input string tag);
      check({tag, "_bvalid"}, 512'(bvalid), 512'(1));
      check({tag, "_b_pending"}, 512'(exp_bresp.size() != 0), 512'(1));
      if (exp_bresp.size() != 0) check({tag, "_bresp"}, 512'(bresp), 512'(exp_bresp.pop_front()));
   endtask

   task automatic pop_r(input string tag);
      check({tag, "_rvalid"}, 512'(rvalid), 512'(1));
      check({tag, "_r_pending"}, 512'(exp_rresp.size() != 0), 512'(1));
      if (exp_rresp.size() != 0) begin
         check({tag, "_rresp"}, 512'(rresp), 512'(exp_rresp.pop_front()));
         check({tag, "_rdata"}, 512'(rdata), 512'(exp_rdata.pop_front()));
      end
   endtask

   task automatic b_hs();
      bready = 1'b1; tick(); bready = 1'b0;
   endtask

   task automatic r_hs();
      rready = 1'b1; tick(); rready = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      awvalid = 1'b0; awaddr = 32'd0; awprot = 3'd0;
      wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; bready = 1'b0;
      arvalid = 1'b0; araddr = 32'd0; arprot = 3'd0; rready = 1'b0;
      exp_pulse = 16'd0;
      for (int k = 0; k < 16; k++) model_q[k] = 32'd0;

      // Reset state
      tick(); tick();
      check("rst_ready", 512'({awready, wready, arready}), 512'(3'b000));
      check("rst_valid", 512'({bvalid, rvalid}), 512'(2'b00));
      check("rst_resp_data", 512'({bresp, rresp, rdata}), 512'(0));
      check("rst_regs", reg_bus, 512'(0));
      check("rst_pulse", 512'(wr_pulse), 512'(0));
      areset = 1'b0;
      tick();
      check("post_rst_ready", 512'({awready, wready, arready}), 512'(3'b111));

      // AW and W together: BVALID one cycle later
      drive_aw(32'h8); drive_w(32'hDEADBEEF, 4'hF); exp_write(32'h8, 32'hDEADBEEF, 4'hF);
      tick(); awvalid = 1'b0; wvalid = 1'b0;
      pop_b("wr8");
      check("wr8_pulse", 512'(wr_pulse), 512'(exp_pulse));
      check("wr8_reg2", 512'(reg_bus[95:64]), 512'(32'hDEADBEEF));
      check("wr8_blocked", 512'({awready, wready}), 512'(2'b00));
      b_hs();
      check("wr8_pulse_clear", 512'(wr_pulse), 512'(0));
      check("wr8_b2b_ready", 512'({awready, wready, bvalid}), 512'(3'b110));

      // W leads AW by three cycles, BREADY held low
      drive_w(32'h12345678, 4'hF);
      tick(); wvalid = 1'b0;
      check("wlead_latched", 512'({awready, wready, bvalid}), 512'(3'b100));
      tick(); tick();
      drive_aw(32'h4); exp_write(32'h4, 32'h12345678, 4'hF);
      tick(); awvalid = 1'b0;
      check("wlead_pulse", 512'(wr_pulse), 512'(exp_pulse));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wlead_hold", 512'({bvalid, awready, wready}), 512'(3'b100));
      end
      pop_b("wlead");
      check("wlead_regs", reg_bus, model_bus());
      b_hs();
      check("wlead_b2b_ready", 512'({awready, wready}), 512'(2'b11));

      // Read reg 2 with RREADY held low
      arvalid = 1'b1; araddr = 32'h8; exp_read(32'h8);
      tick(); arvalid = 1'b0;
      check("rd8_arready_low", 512'(arready), 512'(0));
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rd8_hold", 512'({rvalid, arready, rdata}), 512'({1'b1, 1'b0, 32'hDEADBEEF}));
      end
      pop_r("rd8");
      r_hs();
      check("rd8_b2b_ready", 512'({arready, rvalid}), 512'(2'b10));

      // Out-of-range write and read
      drive_aw(32'h40); drive_w(32'hCAFEF00D, 4'hF); exp_write(32'h40, 32'hCAFEF00D, 4'hF);
      tick(); awvalid = 1'b0; wvalid = 1'b0;
      pop_b("oor_wr");
      check("oor_pulse", 512'(wr_pulse), 512'(exp_pulse));
      check("oor_regs", reg_bus, model_bus());
      b_hs();
      arvalid = 1'b1; araddr = 32'h40; exp_read(32'h40);
      tick(); arvalid = 1'b0;
      pop_r("oor_rd");
      r_hs();

      // Last register and ignored low address bits
      arvalid = 1'b1; araddr = 32'h3C; exp_read(32'h3C);
      tick(); arvalid = 1'b0; pop_r("rd_last"); r_hs();
      arvalid = 1'b1; araddr = 32'h7; exp_read(32'h7);
      tick(); arvalid = 1'b0; pop_r("rd_unaligned"); r_hs();

      // Read and write to the same register on the same edge: read sees old value
      exp_read(32'h8);
      drive_aw(32'h8); drive_w(32'h11112222, 4'hF); exp_write(32'h8, 32'h11112222, 4'hF);
      arvalid = 1'b1; araddr = 32'h8;
      tick(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      pop_b("conc_wr");
      pop_r("conc_rd");
      check("conc_regs", reg_bus, model_bus());
      bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;

      // Byte strobes
      drive_aw(32'h0); drive_w(32'hFFFFFFFF, 4'hF); exp_write(32'h0, 32'hFFFFFFFF, 4'hF);
      tick(); awvalid = 1'b0; wvalid = 1'b0; pop_b("strb_fill"); b_hs();
      drive_aw(32'h0); drive_w(32'h0, 4'b0101); exp_write(32'h0, 32'h0, 4'b0101);
      tick(); awvalid = 1'b0; wvalid = 1'b0; pop_b("strb_0101");
`ifdef AXI_LITE_REG_SLAVE_STRB_EN
      check("strb_0101_reg0", 512'(reg_bus[31:0]), 512'(32'hFF00FF00));
`else
      check("strb_0101_reg0", 512'(reg_bus[31:0]), 512'(32'h00000000));
`endif
      b_hs();
      drive_aw(32'hC); drive_w(32'hA5A5A5A5, 4'b0000); exp_write(32'hC, 32'hA5A5A5A5, 4'b0000);
      tick(); awvalid = 1'b0; wvalid = 1'b0; pop_b("strb_none");
      check("strb_none_pulse", 512'(wr_pulse), 512'(exp_pulse));
      check("strb_none_regs", reg_bus, model_bus());
      b_hs();

      // Reset with AW latched and W pending
      drive_aw(32'h10);
      tick(); awvalid = 1'b0;
      check("abort_aw_latched", 512'({awready, wready}), 512'(2'b01));
      areset = 1'b1;
      for (int k = 0; k < 16; k++) model_q[k] = 32'd0;
      tick();
      check("abort_in_reset", 512'({bvalid, awready, wready, arready}), 512'(4'b0000));
      check("abort_regs", reg_bus, model_bus());
      areset = 1'b0;
      tick();
      check("abort_ready", 512'({awready, wready, arready, bvalid}), 512'(4'b1110));
      drive_w(32'h99999999, 4'hF);
      tick(); wvalid = 1'b0;
      tick();
      check("abort_no_commit", 512'(bvalid), 512'(0));
      check("abort_regs_final", reg_bus, model_bus());
      check("sb_drained", 512'(exp_bresp.size() + exp_rresp.size()), 512'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter S_AXI_DATA_WIDTH, default 32, data width of all channels and registers; only 32 is supported.
REQ-002 Parameter S_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter REG_NUM, default 16, number of 32-bit registers; power of two, 2..256.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 S_AXI_ARESET  in  1  synchronous, active-high reset.
REQ-006 S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored): write-address channel.
REQ-007 S_AXI_WDATA in DATA_WIDTH, S_AXI_WSTRB in DATA_WIDTH/8, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write-data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write-response channel.
REQ-009 S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored): read-address channel.
REQ-010 S_AXI_RDATA out DATA_WIDTH, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read-data channel.
REQ-011 reg_bus  out  REG_NUM*DATA_WIDTH  current register contents; register k at bits [32k+31:32k].
REQ-012 wr_pulse  out  REG_NUM  one-cycle one-hot strobe, bit k high the cycle after register k is written.

Function
REQ-013 Decode: word index = ADDR[log2(REG_NUM)+1:2]; ADDR[1:0] ignored; any set bit above the index field is out of range.
REQ-014 Write path SHALL latch AW and W independently: AWREADY high while no AW latched and BVALID low; WREADY high while no W latched and BVALID low.
REQ-015 Write commits the cycle both AW and W are held (latched or accepted same cycle); at that edge register updates and BVALID rises; minimum latency AW/W handshake -> BVALID = 1 cycle.
REQ-016 In-range write: BRESP=2'b00; out-of-range write: BRESP=2'b10 (SLVERR), no register changes, no wr_pulse.
REQ-017 BVALID and BRESP SHALL hold until BVALID&BREADY; no new AW/W accepted until then.
REQ-018 Read path: ARREADY high while RVALID low; on AR handshake RDATA/RRESP register and RVALID rises next cycle; held stable until RVALID&RREADY.
REQ-019 In-range read: RRESP=2'b00, RDATA=register value; out-of-range: RRESP=2'b10, RDATA=0.
REQ-020 Read and write paths operate concurrently; a read accepted on the same edge a write commits to the same register returns the pre-write value.
REQ-021 Back-to-back: ARREADY SHALL return high the cycle after R handshake; AWREADY/WREADY the cycle after B handshake.
REQ-022 reg_bus updates on the commit edge; wr_pulse asserted exactly one cycle, zero otherwise.

Reset
REQ-023 While S_AXI_ARESET high at a rising edge: AWREADY, WREADY, ARREADY, BVALID, RVALID=0; BRESP, RRESP, RDATA=0; all registers=0; wr_pulse=0; latched AW/W discarded.
REQ-024 Reset mid-transaction aborts it with no response; first cycle after reset AWREADY, WREADY, ARREADY=1.

Configuration
REQ-025 Macro AXI_LITE_REG_SLAVE_STRB_EN defined: write updates only bytes whose WSTRB bit is 1; WSTRB=0 still commits, responds OKAY, pulses wr_pulse.
REQ-026 Macro undefined: WSTRB ignored; every committed write replaces the full 32-bit word.

Verification
REQ-027 Reset, then write 0x0000_0008 <- 0xDEADBEEF with AW and W same cycle -> BVALID one cycle later, BRESP=00, wr_pulse[2] one cycle, reg_bus[95:64]=0xDEADBEEF.
REQ-028 W presented 3 cycles before AW (addr 0x4, data 0x12345678), BREADY low 4 cycles -> BVALID held, AW/WREADY low until B handshake, reg 1=0x12345678.
REQ-029 Read 0x8 after REQ-027 with RREADY low 2 cycles -> RVALID held, RDATA=0xDEADBEEF, RRESP=00, ARREADY low until handshake.
REQ-030 Write/read address 0x40 (REG_NUM=16) -> BRESP=10 and RRESP=10, RDATA=0, no register or wr_pulse change.
REQ-031 STRB_EN defined: reg 0=0xFFFF_FFFF, write 0x0 with WSTRB=4'b0101 -> reg 0=0xFF00_FF00; undefined -> reg 0=0x0000_0000.
REQ-032 Assert reset with AW latched and W pending -> no BVALID, registers 0, READYs high the cycle after reset release.
